regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between N writeback requesters: ALU result, load data and the multicycle mult/div unit.
- Grants one request per cycle using round-robin order and registers the winner onto RegWrite/Write_register/Write_Data for the register file.
- Gives the hazard unit combinational pending-write flags for the rs/rt operands currently being decoded.
- Sits between the writeback sources and the register file, which writes on posedge CLK.

Parameters:
- N_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LOAD, 2 = MULDIV).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- CLK  input  1  clock; all state updates on posedge CLK.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester write request.
- req_ready  output  N_REQ  per-requester accept; combinational, one-hot or zero.
- req_reg  input  N_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  N_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W].
- rs_addr  input  ADDR_W  decode-stage source register 1.
- rt_addr  input  ADDR_W  decode-stage source register 2.
- stall_rs  output  1  rs has a write pending or in flight.
- stall_rt  output  1  rt has a write pending or in flight.
- RegWrite  output  1  registered write enable to the register file.
- Write_register  output  ADDR_W  registered write address.
- Write_Data  output  DATA_W  registered write data.
- grant_id  output  2  registered index of the requester that produced the current RegWrite cycle.

Behaviour:
- Reset values:
  - RegWrite=0, Write_register=0, Write_Data=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - req_ready is forced to all-zero while RESET is high.
- Handshake:
  - A request transfers at a posedge where req_valid[i] && req_ready[i].
  - A requester must hold req_valid, req_reg and req_data stable until accepted.
  - Dropping valid before acceptance is illegal; the bench flags it as an error.
- Arbitration:
  - Search order is ptr, ptr+1, ..., ptr+N_REQ-1, modulo N_REQ.
  - The first valid requester in that order gets req_ready=1. At most one ready bit is ever high.
  - After granting i: ptr <= (i+1) mod N_REQ.
  - With no valid request, ptr holds.
  - Every continuously valid requester is therefore granted within N_REQ cycles.
- Latency:
  - Acceptance at edge k drives RegWrite=1 with the matching address, data and grant_id for cycle k..k+1.
  - The register file updates at edge k+1.
  - With no acceptance at edge k, RegWrite=0 in the following cycle; Write_register and Write_Data hold their last values.
- $zero writes:
  - A request with req_reg==0 is accepted and rotates ptr normally.
  - It produces RegWrite=0; Write_register and Write_Data are not updated.
  - grant_id still updates.
- Throughput: one write per cycle, back-to-back, with no bubble between consecutive grants.
- Hazard flags:
  - stall_rs = (rs_addr!=0) && (any req_valid[i] with req_reg[i]==rs_addr, or RegWrite && Write_register==rs_addr).
  - stall_rt is the same expression using rt_addr.
  - Both flags are purely combinational.
  - The in-flight term exists because the register file's same-cycle read returns the old value.
- Same destination register:
  - When several requesters target the same register, writes land in grant order.
  - Program order between requesters is the issuing units' responsibility; this block does not reorder.
- Reset mid-operation:
  - Any in-flight RegWrite is cancelled immediately (asynchronous clear), and ptr returns to 0.
  - Pending requests are not accepted while RESET is high.
  - They are re-arbitrated from ptr=0 after the first posedge with RESET low.

Test Plan:
- Reset, then drive only req 0 with reg=8, data=0x0000_1234 -> req_ready=001 the same cycle; next cycle RegWrite=1, Write_register=8, Write_Data=0x1234, grant_id=0; then RegWrite=0.
- Hold all three valid (regs 9/10/11, data 0xA/0xB/0xC) -> grants occur in order 0,1,2,0 and so on; RegWrite stays high continuously, with Write_register sequence 9,10,11.
- Drive only req 1 with reg=0, data=0xFFFF_FFFF -> req_ready=010; next cycle RegWrite=0 and grant_id=1; ptr advances so a following 0/1/2 contention grants requester 2 first.
- Pending req 2 to reg 17 with rs_addr=17, rt_addr=0 -> stall_rs=1, stall_rt=0, through the RegWrite cycle; stall_rs=0 the cycle after the write lands.
- Assert RESET asynchronously mid-cycle while RegWrite=1 and all requests valid -> RegWrite drops to 0 before the next edge and req_ready=000; after release, requester 0 is granted first.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback requesters.
// Registers the winning request onto RegWrite/Write_register/Write_Data; flags operand hazards.
module regfile_write_arbiter #(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*ADDR_W-1:0] req_reg,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [ADDR_W-1:0]       rs_addr,
   input  logic [ADDR_W-1:0]       rt_addr,
   output logic                    stall_rs,
   output logic                    stall_rt,
   output logic                    RegWrite,
   output logic [ADDR_W-1:0]       Write_register,
   output logic [DATA_W-1:0]       Write_Data,
   output logic [1:0]              grant_id
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [PtrW-1:0]   grant_idx;
   logic [PtrW-1:0]   cand;
   int unsigned       scan_idx;
   logic              found;
   logic              accept;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;
   logic              hit_rs, hit_rt;

   // Scan from ptr upward, wrapping, and take the first valid requester.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = (int'(ptr_q) + k) % N_REQ;
         cand     = PtrW'(scan_idx);
         if (!found && req_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      accept   = found && !RESET;
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
      sel_reg  = req_reg[grant_idx*ADDR_W +: ADDR_W];
      sel_data = req_data[grant_idx*DATA_W +: DATA_W];
      ptr_d    = ptr_q;
      if (accept) begin
         ptr_d = (grant_idx == PtrW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Writes to $zero are consumed but never reach the register file.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr_q          <= '0;
         RegWrite       <= 1'b0;
         Write_register <= '0;
         Write_Data     <= '0;
         grant_id       <= '0;
      end else begin
         ptr_q    <= ptr_d;
         RegWrite <= accept && (sel_reg != '0);
         if (accept) begin
            grant_id <= 2'(grant_idx);
            if (sel_reg != '0) begin
               Write_register <= sel_reg;
               Write_Data     <= sel_data;
            end
         end
      end
   end

   // The in-flight term covers the register file returning the old value on a same-cycle read.
   always_comb begin
      hit_rs = RegWrite && (Write_register == rs_addr);
      hit_rt = RegWrite && (Write_register == rt_addr);
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == rs_addr)) begin
            hit_rs = 1'b1;
         end
         if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == rt_addr)) begin
            hit_rt = 1'b1;
         end
      end
      stall_rs = (rs_addr != '0) && hit_rs;
      stall_rt = (rt_addr != '0) && hit_rt;
   end

endmodule
